// File: rtl/enc8x3_event_queue.sv
// enc8x3_event_queue: collects events on 8 request lines, keeps them as
// pending bits, and presents one 3-bit line code at a time over a
// valid/ready handshake. Repeat events on a line that is already pending
// are merged into one and counted in a saturating drop counter.
//
// Build option ENC_ROUND_ROBIN_EN:
//   undefined (default) - fixed priority, line 7 highest.
//   defined             - round-robin search starting after the last
//                         loaded line (a 'last' register, reset to 7).
module enc8x3_event_queue #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       req,
  output logic [2:0]       out_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       pend,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy
);

  // Registered state and its next-state values.
  logic [2:0]       code_reg,  code_next;
  logic             valid_reg, valid_next;
  logic [7:0]       pend_reg,  pend_next;
  logic [CNT_W-1:0] drop_reg,  drop_next;

  // Candidates, slot-free condition and the chosen line.
  logic [7:0] cand;
  logic       free;
  logic [2:0] sel;

  // Lines where a new event hits an already pending bit.
  logic [7:0] dup;
  logic [3:0] dup_cnt;

  // The counter sum is kept 4 bits wider so up to 8 drops in one cycle
  // cannot wrap before the saturation check.
  logic [CNT_W+3:0] drop_sum;
  localparam logic [CNT_W+3:0] DROP_MAX = {{4{1'b0}}, {CNT_W{1'b1}}};

  assign cand = pend_reg | req;
  assign free = ~valid_reg | out_ready;

  // One coalescing detector per line.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dup
      assign dup[gi] = pend_reg[gi] & req[gi];
    end
  endgenerate

  // Count of merged events this cycle.
  always_comb begin
    dup_cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      dup_cnt = dup_cnt + {3'b000, dup[i]};
    end
  end

  // Saturating add of this cycle's drops onto the counter.
  always_comb begin
    drop_sum  = {{4{1'b0}}, drop_reg} + {{CNT_W{1'b0}}, dup_cnt};
    drop_next = drop_reg;
    if (drop_sum > DROP_MAX) begin
      drop_next = {CNT_W{1'b1}};
    end else begin
      drop_next = drop_sum[CNT_W-1:0];
    end
  end

`ifdef ENC_ROUND_ROBIN_EN
  logic [2:0] last_reg, last_next;

  // Round-robin pick: first set candidate after the last loaded line,
  // wrapping modulo 8 (the last loaded line itself is searched last).
  always_comb begin
    logic found;
    found = 1'b0;
    sel   = last_reg;
    for (int i = 1; i <= 8; i++) begin
      if (!found && cand[last_reg + 3'(i)]) begin
        sel   = last_reg + 3'(i);
        found = 1'b1;
      end
    end
  end

  // Remember the line of every load so the next search starts after it.
  always_comb begin
    last_next = last_reg;
    if (free && (cand != 8'h00)) begin
      last_next = sel;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg <= 3'b111;
    end else begin
      last_reg <= last_next;
    end
  end
`else
  // Fixed priority pick: highest set candidate wins (ascending scan, last
  // hit kept).
  always_comb begin
    sel = 3'b000;
    for (int i = 0; i < 8; i++) begin
      if (cand[i]) begin
        sel = 3'(i);
      end
    end
  end
`endif

  // Output slot and pending register update.
  always_comb begin
    code_next  = code_reg;
    valid_next = valid_reg;
    pend_next  = cand;
    if (free) begin
      if (cand != 8'h00) begin
        code_next       = sel;
        valid_next      = 1'b1;
        pend_next[sel]  = 1'b0;
      end else begin
        valid_next = 1'b0;
      end
    end
  end

  // State registers; reset wins over any handshake in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_reg  <= 3'b000;
      valid_reg <= 1'b0;
      pend_reg  <= 8'h00;
      drop_reg  <= '0;
    end else begin
      code_reg  <= code_next;
      valid_reg <= valid_next;
      pend_reg  <= pend_next;
      drop_reg  <= drop_next;
    end
  end

  assign out_code  = code_reg;
  assign out_valid = valid_reg;
  assign pend      = pend_reg;
  assign drop_cnt  = drop_reg;
  assign busy      = valid_reg | (|pend_reg);

endmodule

// File: tb/tb_enc8x3_event_queue.sv
// Directed testbench for enc8x3_event_queue. A second instance with
// CNT_W=2 covers drop counter saturation. Expected codes follow
// ENC_ROUND_ROBIN_EN when it is defined.
module tb_enc8x3_event_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       out_ready;
  logic [2:0] out_code;
  logic       out_valid;
  logic [7:0] pend;
  logic [7:0] drop_cnt;
  logic       busy;

  logic [7:0] req2;
  logic       ready2;
  logic [2:0] code2;
  logic       valid2;
  logic [7:0] pend2;
  logic [1:0] drop2;
  logic       busy2;

  int check_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  enc8x3_event_queue #(.CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .req(req), .out_code(out_code), .out_valid(out_valid),
    .out_ready(out_ready), .pend(pend), .drop_cnt(drop_cnt), .busy(busy)
  );

  enc8x3_event_queue #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .req(req2), .out_code(code2), .out_valid(valid2),
    .out_ready(ready2), .pend(pend2), .drop_cnt(drop2), .busy(busy2)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 8'h00; out_ready = 1'b0; req2 = 8'h00; ready2 = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'h00; out_ready = 1'b0; req2 = 8'h00; ready2 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      check_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid c%0d got %b exp 0", c, out_valid); else pass_cnt++;
      check_cnt++; if (pend !== 8'h00) $display("FAIL reset_pend c%0d got %h exp 00", c, pend); else pass_cnt++;
      check_cnt++; if (drop_cnt !== 8'h00) $display("FAIL reset_drop c%0d got %0d exp 0", c, drop_cnt); else pass_cnt++;
      check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy c%0d got %b exp 0", c, busy); else pass_cnt++;
      check_cnt++; if (out_code !== 3'b000) $display("FAIL reset_code c%0d got %0d exp 0", c, out_code); else pass_cnt++;
    end
    rst = 1'b0;
    step();
    check_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy got %b exp 0", busy); else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h20; out_ready = 1'b1;
    step();
    req = 8'h00;
    check_cnt++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", out_valid); else pass_cnt++;
    check_cnt++; if (out_code !== 3'd5) $display("FAIL single_code got %0d exp 5", out_code); else pass_cnt++;
    step();
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL single_after_valid got %b exp 0", out_valid); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL single_after_busy got %b exp 0", busy); else pass_cnt++;
    check_cnt++; if (out_code !== 3'd5) $display("FAIL single_code_hold got %0d exp 5", out_code); else pass_cnt++;
    $display("test_single done");
  endtask

  // Pulse req_val for one cycle with out_ready high and expect the codes
  // in exp_codes (count n) on consecutive cycles, then an idle slot.
  task automatic run_burst(input string name, input logic [7:0] req_val,
                           input logic [2:0] exp_codes [4], input int n);
    do_reset();
    req = req_val; out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      step();
      req = 8'h00;
      check_cnt++; if (out_valid !== 1'b1) $display("FAIL %s_valid%0d got %b exp 1", name, k, out_valid); else pass_cnt++;
      check_cnt++; if (out_code !== exp_codes[k]) $display("FAIL %s_code%0d got %0d exp %0d", name, k, out_code, exp_codes[k]); else pass_cnt++;
    end
    step();
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL %s_end_valid got %b exp 0", name, out_valid); else pass_cnt++;
    check_cnt++; if (drop_cnt !== 8'h00) $display("FAIL %s_drop got %0d exp 0", name, drop_cnt); else pass_cnt++;
    $display("%s done", name);
  endtask

  task automatic test_priority();
    logic [2:0] e [4];
`ifdef ENC_ROUND_ROBIN_EN
    e = '{3'd0, 3'd7, 3'd0, 3'd0};
`else
    e = '{3'd7, 3'd0, 3'd0, 3'd0};
`endif
    run_burst("test_priority", 8'h81, e, 2);
  endtask

  task automatic test_back_to_back();
    logic [2:0] e [4];
`ifdef ENC_ROUND_ROBIN_EN
    e = '{3'd0, 3'd2, 3'd5, 3'd7};
`else
    e = '{3'd7, 3'd5, 3'd2, 3'd0};
`endif
    run_burst("test_back_to_back", 8'hA5, e, 4);
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 8'h04; out_ready = 1'b0;
    step();
    check_cnt++; if (out_code !== 3'd2 || out_valid !== 1'b1) $display("FAIL bp_load got code %0d valid %b exp 2/1", out_code, out_valid); else pass_cnt++;
    req = 8'h08;
    for (int c = 0; c < 3; c++) begin
      step();
      check_cnt++; if (out_code !== 3'd2 || out_valid !== 1'b1) $display("FAIL bp_hold c%0d got code %0d valid %b exp 2/1", c, out_code, out_valid); else pass_cnt++;
    end
    check_cnt++; if (pend !== 8'h08) $display("FAIL bp_pend got %h exp 08", pend); else pass_cnt++;
    check_cnt++; if (drop_cnt !== 8'd2) $display("FAIL bp_drop got %0d exp 2", drop_cnt); else pass_cnt++;
    req = 8'h00; out_ready = 1'b1;
    step();
    check_cnt++; if (out_code !== 3'd3 || out_valid !== 1'b1) $display("FAIL bp_release got code %0d valid %b exp 3/1", out_code, out_valid); else pass_cnt++;
    check_cnt++; if (pend !== 8'h00) $display("FAIL bp_release_pend got %h exp 00", pend); else pass_cnt++;
    step();
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_end_valid got %b exp 0", out_valid); else pass_cnt++;
    check_cnt++; if (drop_cnt !== 8'd2) $display("FAIL bp_drop_keep got %0d exp 2", drop_cnt); else pass_cnt++;
    $display("test_backpressure done");
  endtask

  task automatic test_not_drop();
    do_reset();
    req = 8'h10; out_ready = 1'b0;
    step();
    check_cnt++; if (out_code !== 3'd4) $display("FAIL nd_load got %0d exp 4", out_code); else pass_cnt++;
    step();
    req = 8'h00;
    check_cnt++; if (pend !== 8'h10) $display("FAIL nd_pend got %h exp 10", pend); else pass_cnt++;
    check_cnt++; if (drop_cnt !== 8'd0) $display("FAIL nd_drop got %0d exp 0", drop_cnt); else pass_cnt++;
    out_ready = 1'b1;
    step();
    check_cnt++; if (out_code !== 3'd4 || out_valid !== 1'b1 || pend !== 8'h00) $display("FAIL nd_second got code %0d valid %b pend %h exp 4/1/00", out_code, out_valid, pend); else pass_cnt++;
    step();
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL nd_end_valid got %b exp 0", out_valid); else pass_cnt++;
    $display("test_not_drop done");
  endtask

  task automatic test_coalesce_selected();
    do_reset();
    req = 8'h02; out_ready = 1'b0;
    step();
    req = 8'h01;
    step();
    check_cnt++; if (pend !== 8'h01) $display("FAIL cs_pend got %h exp 01", pend); else pass_cnt++;
    out_ready = 1'b1;
    step();
    req = 8'h00;
    check_cnt++; if (drop_cnt !== 8'd1) $display("FAIL cs_drop got %0d exp 1", drop_cnt); else pass_cnt++;
    check_cnt++; if (out_code !== 3'd0 || pend !== 8'h00) $display("FAIL cs_load got code %0d pend %h exp 0/00", out_code, pend); else pass_cnt++;
    step();
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL cs_single_delivery got valid %b exp 0", out_valid); else pass_cnt++;
    $display("test_coalesce_selected done");
  endtask

  task automatic test_saturation();
    do_reset();
    req2 = 8'h01; ready2 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 4) begin
        check_cnt++; if (drop2 !== 2'd2) $display("FAIL sat_c4 got %0d exp 2", drop2); else pass_cnt++;
      end
      if (c >= 5) begin
        check_cnt++; if (drop2 !== 2'd3) $display("FAIL sat_c%0d got %0d exp 3", c, drop2); else pass_cnt++;
      end
    end
    check_cnt++; if (pend2 !== 8'h01 || code2 !== 3'd0) $display("FAIL sat_state got pend %h code %0d exp 01/0", pend2, code2); else pass_cnt++;
    req2 = 8'h00;
    $display("test_saturation done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 8'h01; out_ready = 1'b0;
    step();
    req = 8'hF0;
    step();
    check_cnt++; if (out_valid !== 1'b1 || pend !== 8'hF0) $display("FAIL rm_setup got valid %b pend %h exp 1/F0", out_valid, pend); else pass_cnt++;
    rst = 1'b1; req = 8'h0F; out_ready = 1'b1;
    step();
    rst = 1'b0; req = 8'h00;
    check_cnt++; if (out_valid !== 1'b0 || pend !== 8'h00) $display("FAIL rm_clear got valid %b pend %h exp 0/00", out_valid, pend); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0 || out_code !== 3'd0) $display("FAIL rm_busy_code got busy %b code %0d exp 0/0", busy, out_code); else pass_cnt++;
    step();
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL rm_req_discarded got valid %b exp 0", out_valid); else pass_cnt++;
    req = 8'h81;
    step();
    req = 8'h00;
`ifdef ENC_ROUND_ROBIN_EN
    check_cnt++; if (out_code !== 3'd0) $display("FAIL rm_first got %0d exp 0", out_code); else pass_cnt++;
    step();
    check_cnt++; if (out_code !== 3'd7) $display("FAIL rm_second got %0d exp 7", out_code); else pass_cnt++;
`else
    check_cnt++; if (out_code !== 3'd7) $display("FAIL rm_first got %0d exp 7", out_code); else pass_cnt++;
    step();
    check_cnt++; if (out_code !== 3'd0) $display("FAIL rm_second got %0d exp 0", out_code); else pass_cnt++;
`endif
    $display("test_reset_mid done");
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; out_ready = 1'b0; req2 = 8'h00; ready2 = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_back_to_back();
    test_backpressure();
    test_not_drop();
    test_coalesce_selected();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
